// File: rtl/led_7seg_scan.sv
// Avalon-MM scanned 7-segment driver: hex or raw digits, PWM brightness,
// per-digit blanking and decimal points, with dead time between digit slots.
module led_7seg_scan #(
   parameter int unsigned DIGITS         = 4,
   parameter int unsigned CLK_DIV        = 1000,
   parameter int unsigned DEAD_CYCLES    = 2,
   parameter int unsigned PWM_BITS       = 4,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned DIG_ACTIVE_LOW = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [2:0]        address,
   input  logic              chipselect,
   input  logic              write_n,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   output logic [7:0]        seg,
   output logic [DIGITS-1:0] dig,
   output logic              frame_tick
);

   localparam int unsigned       PRESC_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PWM_BITS:0] BRIGHT_FULL = {1'b1, {PWM_BITS{1'b0}}};

   localparam logic [2:0] ADDR_HEX    = 3'd0;
   localparam logic [2:0] ADDR_CTRL   = 3'd1;
   localparam logic [2:0] ADDR_BRIGHT = 3'd2;
   localparam logic [2:0] ADDR_STATUS = 3'd3;
   localparam logic [2:0] ADDR_RAW0   = 3'd4;
   localparam logic [2:0] ADDR_RAW1   = 3'd5;

   logic [4*DIGITS-1:0] hex_q;
   logic [8*DIGITS-1:0] raw_q;
   logic                decode_en_q;
   logic [DIGITS-1:0]   dp_mask_q;
   logic [DIGITS-1:0]   blank_mask_q;
   logic [PWM_BITS:0]   bright_q;

   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [2:0]          idx_q, idx_d;
   logic [PWM_BITS-1:0] pwm_q, pwm_d;
   logic [7:0]          seg_q, seg_d;
   logic [DIGITS-1:0]   dig_q, dig_d;
   logic                frame_tick_q, frame_tick_d;

   logic                wr_en;
   logic                presc_wrap;
   logic                idx_last;
   logic                on_d;
   logic [3:0]          nibble;
   logic [31:0]         hex_full;
   logic [63:0]         raw_full;
   logic [7:0]          dp_full;
   logic [7:0]          blank_full;

   function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
      logic [6:0] s;
      unique case (h)
         4'h0: s = 7'h3F;
         4'h1: s = 7'h06;
         4'h2: s = 7'h5B;
         4'h3: s = 7'h4F;
         4'h4: s = 7'h66;
         4'h5: s = 7'h6D;
         4'h6: s = 7'h7D;
         4'h7: s = 7'h07;
         4'h8: s = 7'h7F;
         4'h9: s = 7'h6F;
         4'hA: s = 7'h77;
         4'hB: s = 7'h7C;
         4'hC: s = 7'h39;
         4'hD: s = 7'h5E;
         4'hE: s = 7'h79;
         4'hF: s = 7'h71;
      endcase
      return s;
   endfunction

   assign wr_en = chipselect && !write_n;

   // Zero-padded 8-digit views so unused digits read back as 0.
   always_comb begin
      hex_full   = '0;
      raw_full   = '0;
      dp_full    = '0;
      blank_full = '0;
      hex_full[4*DIGITS-1:0]   = hex_q;
      raw_full[8*DIGITS-1:0]   = raw_q;
      dp_full[DIGITS-1:0]      = dp_mask_q;
      blank_full[DIGITS-1:0]   = blank_mask_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hex_q        <= '0;
         raw_q        <= '0;
         decode_en_q  <= 1'b1;
         dp_mask_q    <= '0;
         blank_mask_q <= '0;
         bright_q     <= BRIGHT_FULL;
      end else if (wr_en) begin
         case (address)
            ADDR_HEX: hex_q <= writedata[4*DIGITS-1:0];
            ADDR_CTRL: begin
               decode_en_q  <= writedata[0];
               dp_mask_q    <= writedata[8 +: DIGITS];
               blank_mask_q <= writedata[16 +: DIGITS];
            end
            ADDR_BRIGHT: begin
               bright_q <= (writedata > 32'(BRIGHT_FULL)) ? BRIGHT_FULL
                                                          : writedata[PWM_BITS:0];
            end
            ADDR_RAW0: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (i < 4) raw_q[8*i +: 8] <= writedata[8*(i%4) +: 8];
               end
            end
            ADDR_RAW1: begin
               for (int i = 0; i < DIGITS; i++) begin
                  if (i >= 4) raw_q[8*i +: 8] <= writedata[8*(i%4) +: 8];
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_HEX:    readdata = hex_full;
         ADDR_CTRL:   readdata = {8'h00, blank_full, dp_full, 7'h00, decode_en_q};
         ADDR_BRIGHT: readdata = {{(31-PWM_BITS){1'b0}}, bright_q};
         ADDR_STATUS: readdata = {29'h0, idx_q};
         ADDR_RAW0:   readdata = raw_full[31:0];
         ADDR_RAW1:   readdata = raw_full[63:32];
         default:     readdata = '0;
      endcase
   end

   // seg/dig are computed from the next counter state so the registered
   // outputs line up with the slot they belong to (no overlap at boundaries).
   always_comb begin
      presc_wrap   = (presc_q == PRESC_W'(CLK_DIV - 1));
      idx_last     = (idx_q == 3'(DIGITS - 1));
      presc_d      = presc_wrap ? '0 : presc_q + 1'b1;
      idx_d        = presc_wrap ? (idx_last ? 3'd0 : idx_q + 3'd1) : idx_q;
      pwm_d        = pwm_q + 1'b1;
      frame_tick_d = presc_wrap && idx_last;

      on_d = (presc_d >= PRESC_W'(DEAD_CYCLES)) && !blank_full[idx_d]
             && ({1'b0, pwm_d} < bright_q);

      dig_d = '0;
      for (int i = 0; i < DIGITS; i++) begin
         dig_d[i] = on_d && (idx_d == 3'(i));
      end

      nibble = hex_full[4*idx_d +: 4];
      seg_d  = decode_en_q ? {dp_full[idx_d], hex_to_seg(nibble)} : raw_full[8*idx_d +: 8];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         presc_q      <= '0;
         idx_q        <= '0;
         pwm_q        <= '0;
         seg_q        <= '0;
         dig_q        <= '0;
         frame_tick_q <= 1'b0;
      end else begin
         presc_q      <= presc_d;
         idx_q        <= idx_d;
         pwm_q        <= pwm_d;
         seg_q        <= seg_d;
         dig_q        <= dig_d;
         frame_tick_q <= frame_tick_d;
      end
   end

   assign seg        = (SEG_ACTIVE_LOW != 0) ? ~seg_q : seg_q;
   assign dig        = (DIG_ACTIVE_LOW != 0) ? ~dig_q : dig_q;
   assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_led_7seg_scan.sv
// Directed bench for led_7seg_scan: 4 digits, 8-clk slots, 2 dead cycles,
// 2-bit PWM, active-low seg and dig.
module tb_led_7seg_scan;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [7:0]  seg;
   logic [3:0]  dig;
   logic        frame_tick;

   int checks = 0;
   int passes = 0;

   always #5 clk = ~clk;

   led_7seg_scan #(
      .DIGITS        (4),
      .CLK_DIV       (8),
      .DEAD_CYCLES   (2),
      .PWM_BITS      (2),
      .SEG_ACTIVE_LOW(1),
      .DIG_ACTIVE_LOW(1)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .address   (address),
      .chipselect(chipselect),
      .write_n   (write_n),
      .writedata (writedata),
      .readdata  (readdata),
      .seg       (seg),
      .dig       (dig),
      .frame_tick(frame_tick)
   );

   // Expected pin-level dig for cycle c of a frame (c = 0 is the frame_tick cycle).
   // PWM counter equals slot position mod 4 because both reset together.
   function automatic logic [3:0] exp_dig(input int c, input logic [3:0] blank, input int bright);
      int k = (c / 8) % 4;
      int p = c % 8;
      logic [3:0] d = 4'hF;
      if (p >= 2 && !blank[k] && (p % 4) < bright) d[k] = 1'b0;
      return d;
   endfunction

   task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      chipselect = 1'b1;
      write_n    = 1'b0;
      address    = a;
      writedata  = d;
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic sync_frame(output bit ok);
      int n = 0;
      ok = 1'b1;
      @(negedge clk);
      while (frame_tick !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (frame_tick !== 1'b1) begin
         $display("FAIL sync_frame: frame_tick=%b after %0d cycles, required 1", frame_tick, n);
         ok = 1'b0;
      end else passes++;
   endtask

   task automatic test_reset();
      int n;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (13) @(negedge clk);
      checks++;
      if (dig !== 4'hD) $display("FAIL reset_prescan: dig=%h required D", dig);
      else passes++;
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if (seg !== 8'hFF) $display("FAIL reset_seg: seg=%h required FF", seg);
      else passes++;
      checks++;
      if (dig !== 4'hF) $display("FAIL reset_dig: dig=%h required F", dig);
      else passes++;
      checks++;
      if (frame_tick !== 1'b0) $display("FAIL reset_tick: frame_tick=%b required 0", frame_tick);
      else passes++;
      address = 3'd1;
      #1;
      checks++;
      if (readdata !== 32'h00000001) $display("FAIL reset_ctrl: read=%h required 00000001", readdata);
      else passes++;
      address = 3'd2;
      #1;
      checks++;
      if (readdata !== 32'h00000004) $display("FAIL reset_bright: read=%h required 00000004", readdata);
      else passes++;
      address = 3'd0;
      #1;
      checks++;
      if (readdata !== 32'h0) $display("FAIL reset_hex: read=%h required 00000000", readdata);
      else passes++;
      @(negedge clk);
      reset_n = 1'b1;
      address = 3'd3;
      repeat (2) @(negedge clk);
      checks++;
      if (dig !== 4'hE || seg !== 8'hC0)
         $display("FAIL restart_digit0: dig=%h seg=%h required E C0", dig, seg);
      else passes++;
      checks++;
      if (readdata !== 32'h0) $display("FAIL restart_status: read=%h required 0", readdata);
      else passes++;
      n = 2;
      while (frame_tick !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 32) $display("FAIL first_tick: cycles=%0d required 32", n);
      else passes++;
   endtask

   task automatic test_hex_decode();
      logic [7:0] es [4] = '{8'hF9, 8'hC6, 8'hB0, 8'h88};
      bit ok;
      bus_write(3'd0, 32'h0000A3C1);
      sync_frame(ok);
      if (ok) begin
         for (int c = 0; c < 32; c++) begin
            checks++;
            if (dig !== exp_dig(c, 4'h0, 4))
               $display("FAIL hex_dig c=%0d: dig=%h required %h", c, dig, exp_dig(c, 4'h0, 4));
            else passes++;
            checks++;
            if (seg !== es[c/8]) $display("FAIL hex_seg c=%0d: seg=%h required %h", c, seg, es[c/8]);
            else passes++;
            if (c > 0) begin
               checks++;
               if (frame_tick !== 1'b0) $display("FAIL hex_tick c=%0d: frame_tick=%b required 0", c, frame_tick);
               else passes++;
            end
            @(negedge clk);
         end
         checks++;
         if (frame_tick !== 1'b1) $display("FAIL tick_period: frame_tick=%b required 1", frame_tick);
         else passes++;
      end
   endtask

   task automatic test_raw_dp_blank();
      logic [7:0] es_raw [4] = '{8'h80, 8'hFE, 8'h7F, 8'h00};
      logic [7:0] es_dec [4] = '{8'h40, 8'hC0, 8'hC0, 8'hC0};
      bit ok;
      bus_write(3'd1, 32'h00040100);
      bus_write(3'd4, 32'hFF80017F);
      sync_frame(ok);
      if (ok) begin
         for (int c = 0; c < 32; c++) begin
            checks++;
            if (dig !== exp_dig(c, 4'b0100, 4))
               $display("FAIL raw_dig c=%0d: dig=%h required %h", c, dig, exp_dig(c, 4'b0100, 4));
            else passes++;
            checks++;
            if (seg !== es_raw[c/8]) $display("FAIL raw_seg c=%0d: seg=%h required %h", c, seg, es_raw[c/8]);
            else passes++;
            @(negedge clk);
         end
      end
      bus_write(3'd0, 32'h00000000);
      bus_write(3'd1, 32'h00040101);
      sync_frame(ok);
      if (ok) begin
         for (int c = 0; c < 32; c++) begin
            checks++;
            if (dig !== exp_dig(c, 4'b0100, 4))
               $display("FAIL dp_dig c=%0d: dig=%h required %h", c, dig, exp_dig(c, 4'b0100, 4));
            else passes++;
            checks++;
            if (seg !== es_dec[c/8]) $display("FAIL dp_seg c=%0d: seg=%h required %h", c, seg, es_dec[c/8]);
            else passes++;
            @(negedge clk);
         end
      end
   endtask

   task automatic test_brightness();
      int br [3] = '{2, 0, 4};
      logic [31:0] wr [3] = '{32'h2, 32'h0, 32'h1F};
      bit ok;
      bus_write(3'd1, 32'h00000001);
      for (int t = 0; t < 3; t++) begin
         bus_write(3'd2, wr[t]);
         address = 3'd2;
         #1;
         checks++;
         if (readdata !== 32'(br[t])) $display("FAIL bright_read: read=%h required %h", readdata, br[t]);
         else passes++;
         sync_frame(ok);
         if (ok) begin
            for (int c = 0; c < 32; c++) begin
               checks++;
               if (dig !== exp_dig(c, 4'h0, br[t]))
                  $display("FAIL bright%0d_dig c=%0d: dig=%h required %h", br[t], c, dig,
                           exp_dig(c, 4'h0, br[t]));
               else passes++;
               @(negedge clk);
            end
         end
      end
   endtask

   task automatic test_overlap_wrap();
      bit ok;
      chipselect = 1'b1;
      write_n    = 1'b1;
      address    = 3'd3;
      sync_frame(ok);
      if (ok) begin
         for (int c = 0; c < 96; c++) begin
            checks++;
            if ($countones(~dig) > 1) $display("FAIL overlap c=%0d: dig=%h required at most one low", c, dig);
            else passes++;
            checks++;
            if (readdata !== 32'((c / 8) % 4))
               $display("FAIL status c=%0d: read=%h required %h", c, readdata, (c / 8) % 4);
            else passes++;
            @(negedge clk);
         end
         checks++;
         if (readdata !== 32'h0) $display("FAIL status_wrap: read=%h required 0", readdata);
         else passes++;
         // Write on the edge that starts slot 1.
         repeat (7) @(negedge clk);
         write_n   = 1'b0;
         address   = 3'd0;
         writedata = 32'h000000E0;
         @(posedge clk);
         #1;
         write_n = 1'b1;
         address = 3'd3;
         repeat (3) @(negedge clk);
         checks++;
         if (seg !== 8'h86 || dig !== 4'hD)
            $display("FAIL boundary_write: seg=%h dig=%h required 86 D", seg, dig);
         else passes++;
         checks++;
         if (readdata !== 32'h1) $display("FAIL boundary_status: read=%h required 1", readdata);
         else passes++;
      end
      chipselect = 1'b0;
   endtask

   task automatic test_addr_decode();
      logic [31:0] exp_rd [8] = '{32'h000000E0, 32'h00000001, 32'h00000004, 32'h0,
                                  32'hFF80017F, 32'h0, 32'h0, 32'h0};
      bus_write(3'd3, 32'hFFFFFFFF);
      bus_write(3'd6, 32'hFFFFFFFF);
      bus_write(3'd7, 32'hFFFFFFFF);
      bus_write(3'd5, 32'h12345678);
      @(negedge clk);
      chipselect = 1'b0;
      write_n    = 1'b0;
      for (int a = 0; a < 3; a++) begin
         address   = 3'(a);
         writedata = (a == 1) ? 32'h00FFFF00 : 32'hFFFFFFFF;
         repeat (2) @(negedge clk);
      end
      write_n = 1'b1;
      for (int a = 0; a < 8; a++) begin
         address = 3'(a);
         #1;
         checks++;
         if (a == 3) begin
            if (readdata[31:3] !== 29'h0) $display("FAIL decode_status_hi: read=%h required upper bits 0", readdata);
            else passes++;
         end else if (readdata !== exp_rd[a]) begin
            $display("FAIL decode_read%0d: read=%h required %h", a, readdata, exp_rd[a]);
         end else passes++;
      end
   endtask

   initial begin
      reset_n    = 1'b0;
      address    = 3'd0;
      chipselect = 1'b0;
      write_n    = 1'b1;
      writedata  = 32'h0;
      test_reset();
      test_hex_decode();
      test_raw_dp_blank();
      test_brightness();
      test_overlap_wrap();
      test_addr_decode();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
